// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline-register bus: ID-stage instruction fields, MEM write-back bypass,
// pipeline control in, and the registered EX-stage view plus the ID stall out.
interface id_ex_reg_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        id_rf_we;
  logic        id_mem_rd;
  logic        id_rd1_pc_Sel;
  logic        id_rd2_Imm_Sel;
  logic        id_unsigned_Sel;
  logic [3:0]  id_ALU_Sel;
  logic        mem_rf_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_wdata;
  logic        flush;
  logic        ex_hold;

  logic        ex_valid;
  logic        ex_rf_we;
  logic        ex_mem_rd;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic        rd1_pc_Sel;
  logic        rd2_Imm_Sel;
  logic        unsigned_Sel;
  logic [3:0]  ALU_Sel;
  logic        Forward_A_Sel;
  logic        Forward_B_Sel;
  logic        id_stall;

  modport master (
    output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
           id_rs1_used, id_rs2_used, id_rf_we, id_mem_rd, id_rd1_pc_Sel,
           id_rd2_Imm_Sel, id_unsigned_Sel, id_ALU_Sel, mem_rf_we, mem_rd,
           mem_wdata, flush, ex_hold,
    input  ex_valid, ex_rf_we, ex_mem_rd, ex_rd, ex_pc, ex_rd1, ex_rd2, ex_imm,
           rd1_pc_Sel, rd2_Imm_Sel, unsigned_Sel, ALU_Sel, Forward_A_Sel,
           Forward_B_Sel, id_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
           id_rs1_used, id_rs2_used, id_rf_we, id_mem_rd, id_rd1_pc_Sel,
           id_rd2_Imm_Sel, id_unsigned_Sel, id_ALU_Sel, mem_rf_we, mem_rd,
           mem_wdata, flush, ex_hold,
    output ex_valid, ex_rf_we, ex_mem_rd, ex_rd, ex_pc, ex_rd1, ex_rd2, ex_imm,
           rd1_pc_Sel, rd2_Imm_Sel, unsigned_Sel, ALU_Sel, Forward_A_Sel,
           Forward_B_Sel, id_stall
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall detection, EX-forward select capture
// and MEM write-back bypass of the register-file read data.
module id_ex_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       cpu_clk,
  input logic       cpu_rst,
  id_ex_reg_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic        mem_rd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        rd1_pc_sel;
    logic        rd2_imm_sel;
    logic        unsigned_sel;
    logic [3:0]  alu_sel;
    logic        fwd_a;
    logic        fwd_b;
  } ex_t;

  ex_t  ex_q, ex_d, cap;
  logic load_use;
  logic fwd_a, fwd_b;
  logic byp_1, byp_2;
  logic ex_writes_alu;

  always_comb begin
    ex_writes_alu = ex_q.valid & ex_q.rf_we & ~ex_q.mem_rd & (ex_q.rd != 5'd0);
    fwd_a = bus.id_rs1_used & ex_writes_alu & (bus.id_rs1 == ex_q.rd);
    fwd_b = bus.id_rs2_used & ex_writes_alu & (bus.id_rs2 == ex_q.rd);
    byp_1 = bus.mem_rf_we & (bus.mem_rd != 5'd0) & (bus.mem_rd == bus.id_rs1);
    byp_2 = bus.mem_rf_we & (bus.mem_rd != 5'd0) & (bus.mem_rd == bus.id_rs2);
    // Load result is not available until MEM, so a consumer in ID must wait one cycle.
    load_use = bus.id_valid & ex_q.valid & ex_q.mem_rd & (ex_q.rd != 5'd0) &
               ((bus.id_rs1_used & (bus.id_rs1 == ex_q.rd)) |
                (bus.id_rs2_used & (bus.id_rs2 == ex_q.rd)));
  end

  always_comb begin
    cap              = '0;
    cap.valid        = 1'b1;
    cap.rf_we        = bus.id_rf_we;
    cap.mem_rd       = bus.id_mem_rd;
    cap.rd           = bus.id_rd;
    cap.pc           = bus.id_pc;
    cap.rd1          = byp_1 ? bus.mem_wdata : bus.id_rd1;
    cap.rd2          = byp_2 ? bus.mem_wdata : bus.id_rd2;
    cap.imm          = bus.id_imm;
    cap.rd1_pc_sel   = bus.id_rd1_pc_Sel;
    cap.rd2_imm_sel  = bus.id_rd2_Imm_Sel;
    cap.unsigned_sel = bus.id_unsigned_Sel;
    cap.alu_sel      = bus.id_ALU_Sel;
    cap.fwd_a        = fwd_a;
    cap.fwd_b        = fwd_b;
  end

  always_comb begin
    ex_d = '0;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.ex_hold) begin
      ex_d = ex_q;
    end else if (load_use || !bus.id_valid) begin
      ex_d = '0;
    end else begin
      ex_d = cap;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      ex_q    <= '0;
      ex_q.pc <= RESET_PC;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.id_stall      = ~bus.flush & (bus.ex_hold | load_use);
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_rf_we      = ex_q.rf_we;
  assign bus.ex_mem_rd     = ex_q.mem_rd;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rd1        = ex_q.rd1;
  assign bus.ex_rd2        = ex_q.rd2;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.rd1_pc_Sel    = ex_q.rd1_pc_sel;
  assign bus.rd2_Imm_Sel   = ex_q.rd2_imm_sel;
  assign bus.unsigned_Sel  = ex_q.unsigned_sel;
  assign bus.ALU_Sel       = ex_q.alu_sel;
  assign bus.Forward_A_Sel = ex_q.fwd_a;
  assign bus.Forward_B_Sel = ex_q.fwd_b;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed-vector bench for id_ex_reg: a sequential table of {inputs, expected stall,
// expected EX outputs}, then a short hand sequence probing id_stall combinationally.
module tb_id_ex_reg;

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        hold;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mwd;
  } ctl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1u;
    logic        rs2u;
    logic [4:0]  rd;
    logic        rf_we;
    logic        mem_rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic        mem_rd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        fa;
    logic        fb;
  } out_t;

  typedef struct packed {
    ctl_t c;
    in_t  i;
    logic stall;
    out_t o;
  } vec_t;

  localparam int NVec = 24;
  localparam logic [31:0] RstPc = 32'h8000_0000;

  logic cpu_clk;
  logic cpu_rst;
  int   n_vec;
  int   miscompares;
  vec_t vec [NVec];

  id_ex_reg_if bus ();

  id_ex_reg #(.RESET_PC(RstPc)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Control fields are derived from the PC so each instruction carries a distinct pattern.
  function automatic logic [38:0] ctl_of(input logic [31:0] pc);
    return {pc ^ 32'h5A5A_0F0F, pc[5:2] ^ 4'h9, ~pc[2], pc[3], ~pc[4]};
  endfunction

  task automatic drive(input vec_t v);
    logic [38:0] c;
    c = ctl_of(v.i.pc);
    cpu_rst             = v.c.rst;
    bus.flush           = v.c.flush;
    bus.ex_hold         = v.c.hold;
    bus.mem_rf_we       = v.c.mwe;
    bus.mem_rd          = v.c.mrd;
    bus.mem_wdata       = v.c.mwd;
    bus.id_valid        = v.i.valid;
    bus.id_pc           = v.i.pc;
    bus.id_rs1          = v.i.rs1;
    bus.id_rs2          = v.i.rs2;
    bus.id_rs1_used     = v.i.rs1u;
    bus.id_rs2_used     = v.i.rs2u;
    bus.id_rd           = v.i.rd;
    bus.id_rf_we        = v.i.rf_we;
    bus.id_mem_rd       = v.i.mem_rd;
    bus.id_rd1          = v.i.rd1;
    bus.id_rd2          = v.i.rd2;
    bus.id_imm          = c[38:7];
    bus.id_ALU_Sel      = c[6:3];
    bus.id_rd1_pc_Sel   = c[2];
    bus.id_rd2_Imm_Sel  = c[1];
    bus.id_unsigned_Sel = c[0];
  endtask

  task automatic check_stall(input string tag, input logic want);
    n_vec++;
    if (bus.id_stall !== want) begin
      miscompares++;
      $display("FAIL %s id_stall got %b want %b", tag, bus.id_stall, want);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    out_t        act;
    logic [38:0] ctl_act;
    logic [38:0] ctl_exp;
    drive(v);
    #1;
    check_stall($sformatf("vec%0d", idx), v.stall);
    @(posedge cpu_clk);
    #1;
    act = '{bus.ex_valid, bus.ex_rf_we, bus.ex_mem_rd, bus.ex_rd, bus.ex_pc, bus.ex_rd1,
            bus.ex_rd2, bus.Forward_A_Sel, bus.Forward_B_Sel};
    ctl_act = {bus.ex_imm, bus.ALU_Sel, bus.rd1_pc_Sel, bus.rd2_Imm_Sel, bus.unsigned_Sel};
    ctl_exp = v.o.valid ? ctl_of(v.o.pc) : 39'd0;
    n_vec++;
    if (act !== v.o) begin
      miscompares++;
      $display("FAIL vec%0d ex_outputs got %h want %h", idx, act, v.o);
    end
    n_vec++;
    if (ctl_act !== ctl_exp) begin
      miscompares++;
      $display("FAIL vec%0d ex_control got %h want %h", idx, ctl_act, ctl_exp);
    end
  endtask

  initial begin
    vec_t v;
    n_vec       = 0;
    miscompares = 0;

    // reset, with RESET_PC on ex_pc
    vec[0]  = '{'{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0}, '0, 1'b0,
                '{1'b0, 1'b0, 1'b0, 5'd0, RstPc, 32'h0, 32'h0, 1'b0, 1'b0}};
    // add x5 <- x1, x2
    vec[1]  = '{'0, '{1'b1, 32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 32'h11, 32'h22},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd5, 32'h100, 32'h11, 32'h22, 1'b0, 1'b0}};
    // sub rs1=x5 right behind: EX forward A
    vec[2]  = '{'0, '{1'b1, 32'h104, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 32'h33, 32'h44},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd6, 32'h104, 32'h33, 32'h44, 1'b1, 1'b0}};
    // lw x7
    vec[3]  = '{'0, '{1'b1, 32'h108, 5'd2, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'h55, 32'h66},
                1'b0, '{1'b1, 1'b1, 1'b1, 5'd7, 32'h108, 32'h55, 32'h66, 1'b0, 1'b0}};
    // add rs2=x7: load-use stall, bubble
    vec[4]  = '{'{1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h1234},
                '{1'b1, 32'h10C, 5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h77, 32'h88},
                1'b1, '0};
    // same add retried, load data bypassed from MEM
    vec[5]  = '{'{1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF},
                '{1'b1, 32'h10C, 5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h77, 32'h88},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd8, 32'h10C, 32'h77, 32'hDEAD_BEEF, 1'b0, 1'b0}};
    // lw x7 again
    vec[6]  = '{'0, '{1'b1, 32'h110, 5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 32'h99, 32'hAA},
                1'b0, '{1'b1, 1'b1, 1'b1, 5'd7, 32'h110, 32'h99, 32'hAA, 1'b0, 1'b0}};
    // add rs1=x7 with flush: no stall, bubble
    vec[7]  = '{'{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0},
                '{1'b1, 32'h114, 5'd7, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'hBB, 32'hCC},
                1'b0, '0};
    // target instruction captured at once, MEM bypass on rs1
    vec[8]  = '{'{1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h5A5A_5A5A},
                '{1'b1, 32'h118, 5'd7, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'hBB, 32'hCC},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd9, 32'h118, 32'h5A5A_5A5A, 32'hCC, 1'b0, 1'b0}};
    // instruction at 0x40 with forward A set
    vec[9]  = '{'0, '{1'b1, 32'h40, 5'd9, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 32'h1, 32'h2},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd10, 32'h40, 32'h1, 32'h2, 1'b1, 1'b0}};
    // three hold cycles with varying ID inputs
    vec[10] = '{'{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0},
                '{1'b1, 32'h44, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 32'h3, 32'h4},
                1'b1, '{1'b1, 1'b1, 1'b0, 5'd10, 32'h40, 32'h1, 32'h2, 1'b1, 1'b0}};
    vec[11] = '{'{1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 32'hFFFF_0000},
                '{1'b1, 32'h48, 5'd10, 5'd10, 1'b1, 1'b1, 5'd12, 1'b0, 1'b1, 32'h5, 32'h6},
                1'b1, '{1'b1, 1'b1, 1'b0, 5'd10, 32'h40, 32'h1, 32'h2, 1'b1, 1'b0}};
    vec[12] = '{'{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0}, '0,
                1'b1, '{1'b1, 1'b1, 1'b0, 5'd10, 32'h40, 32'h1, 32'h2, 1'b1, 1'b0}};
    // release: next instruction, forward A and B
    vec[13] = '{'0, '{1'b1, 32'h44, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 32'h3, 32'h4},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd11, 32'h44, 32'h3, 32'h4, 1'b1, 1'b1}};
    // rd=0 producer
    vec[14] = '{'{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF},
                '{1'b1, 32'h48, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 32'h5, 32'h6},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd0, 32'h48, 32'h5, 32'h6, 1'b0, 1'b0}};
    // consumer of x0: no forward, no bypass from mem_rd=0
    vec[15] = '{'{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF},
                '{1'b1, 32'h4C, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 32'h7, 32'h8},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd12, 32'h4C, 32'h7, 32'h8, 1'b0, 1'b0}};
    // id_valid=0 with live-looking fields: bubble
    vec[16] = '{'0, '{1'b0, 32'h50, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b1, 32'h9, 32'h9},
                1'b0, '0};
    vec[17] = '{'0, '{1'b1, 32'h60, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 32'h9, 32'hA},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd13, 32'h60, 32'h9, 32'hA, 1'b0, 1'b0}};
    vec[18] = '{'{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0},
                '{1'b1, 32'h64, 5'd13, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 32'hB, 32'hC},
                1'b1, '{1'b1, 1'b1, 1'b0, 5'd13, 32'h60, 32'h9, 32'hA, 1'b0, 1'b0}};
    // reset during hold; id_stall is not gated by reset
    vec[19] = '{'{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0},
                '{1'b1, 32'h64, 5'd13, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 32'hB, 32'hC},
                1'b1, '{1'b0, 1'b0, 1'b0, 5'd0, RstPc, 32'h0, 32'h0, 1'b0, 1'b0}};
    // first post-reset edge: normal capture, no forward from reset state
    vec[20] = '{'0, '{1'b1, 32'h64, 5'd13, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 32'hB, 32'hC},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd14, 32'h64, 32'hB, 32'hC, 1'b0, 1'b0}};
    // flush beats hold
    vec[21] = '{'{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0},
                '{1'b1, 32'h68, 5'd14, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 32'hD, 32'hE},
                1'b0, '0};
    vec[22] = '{'0, '{1'b1, 32'h68, 5'd1, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 32'hD, 32'hE},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd15, 32'h68, 32'hD, 32'hE, 1'b0, 1'b0}};
    // EX forward and MEM bypass both match rs1
    vec[23] = '{'{1'b0, 1'b0, 1'b0, 1'b1, 5'd15, 32'hCAFE_0000},
                '{1'b1, 32'h6C, 5'd15, 5'd2, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 32'h1, 32'h2},
                1'b0, '{1'b1, 1'b1, 1'b0, 5'd16, 32'h6C, 32'hCAFE_0000, 32'h2, 1'b1, 1'b0}};

    for (int k = 0; k < NVec; k++) begin
      apply(k, vec[k]);
    end

    // Hand sequence: id_stall follows flush/hold/rs-use combinationally with a load in EX.
    v = '{'0, '{1'b1, 32'h70, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0, 32'h0},
          1'b0, '0};
    drive(v);
    @(posedge cpu_clk);
    #1;
    n_vec++;
    if ({bus.ex_mem_rd, bus.ex_rd} !== {1'b1, 5'd3}) begin
      miscompares++;
      $display("FAIL seq_lw_capture got %b_%0d want 1_3", bus.ex_mem_rd, bus.ex_rd);
    end
    bus.id_rs1      = 5'd3;
    bus.id_rs1_used = 1'b1;
    #1;
    check_stall("seq_load_use", 1'b1);
    bus.flush = 1'b1;
    #1;
    check_stall("seq_flush_masks", 1'b0);
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b1;
    #1;
    check_stall("seq_hold", 1'b1);
    bus.ex_hold     = 1'b0;
    bus.id_rs1_used = 1'b0;
    #1;
    check_stall("seq_rs1_unused", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
